rvx_dma: RTL

Single-channel memory-to-memory copy engine that acts as a bus initiator on the RVX peripheral bus protocol. Software configures source, destination and word count through a responder-side register port and starts the transfer. The engine then issues alternating read and write requests on its initiator port until the count is exhausted, and optionally raises an interrupt. It sits beside the CPU as a second bus master in front of the system bus arbiter.

---
 rtl/rvx_dma_pkg.sv | 20 ++
 rtl/rvx_dma_if.sv | 21 ++
 rtl/rvx_dma_regs.sv | 67 ++++++
 rtl/rvx_dma.sv | 115 +++++++++++
 4 files changed

// File: rtl/rvx_dma_pkg.sv
// Shared register indices, CR bit positions and FSM states for the DMA engine.
package rvx_dma_pkg;
  localparam logic [2:0] REG_CR     = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_REMAIN = 3'd4;

  localparam int CR_START = 0;
  localparam int CR_DONE  = 1;
  localparam int CR_IE    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } state_t;
endpackage

// File: rtl/rvx_dma_if.sv
// RVX peripheral bus: one request/response pair per direction, 32-bit data.
interface rvx_dma_if #(parameter int AW = 32);
  logic [AW-1:0] address;
  logic [31:0]   read_data;
  logic          read_request;
  logic          read_response;
  logic [31:0]   write_data;
  logic [3:0]    write_strobe;
  logic          write_request;
  logic          write_response;

  modport master (
    output address, read_request, write_data, write_strobe, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  address, read_request, write_data, write_strobe, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/rvx_dma_regs.sv
// Config-port decode and register file; responses one cycle after each request.
// start/done_clr are combinational pulses so the FSM can react at the write edge.
module rvx_dma_regs
  import rvx_dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  rvx_dma_if.slave    cfg,
  input  logic        busy,
  input  logic        done,
  input  logic [15:0] remain,
  output logic        start,
  output logic        done_clr,
  output logic        ie,
  output logic        ie_nxt,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [15:0] len
);
  logic [2:0] idx;
  logic       wr_ok;
  logic       rd_ok;
  logic       cr_wr;

  assign idx      = cfg.address[4:2];
  assign wr_ok    = cfg.write_request && (cfg.write_strobe == 4'b1111) && (cfg.address[1:0] == 2'b00);
  assign rd_ok    = cfg.read_request && (cfg.address[1:0] == 2'b00);
  assign cr_wr    = wr_ok && (idx == REG_CR);
  assign start    = cr_wr && cfg.write_data[CR_START] && !busy;
  assign done_clr = cr_wr && cfg.write_data[CR_DONE];
  assign ie_nxt   = cr_wr ? cfg.write_data[CR_IE] : ie;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg.read_data      <= '0;
      cfg.read_response  <= 1'b0;
      cfg.write_response <= 1'b0;
      ie                 <= 1'b0;
      src                <= '0;
      dst                <= '0;
      len                <= '0;
    end else begin
      cfg.read_response  <= cfg.read_request;
      cfg.write_response <= cfg.write_request;
      ie                 <= ie_nxt;
      // Address and length registers are frozen while a copy is running.
      if (wr_ok && !busy) begin
        case (idx)
          REG_SRC: src <= {cfg.write_data[31:2], 2'b00};
          REG_DST: dst <= {cfg.write_data[31:2], 2'b00};
          REG_LEN: len <= cfg.write_data[15:0];
          default: ;
        endcase
      end
      if (rd_ok) begin
        case (idx)
          REG_CR:     cfg.read_data <= {29'd0, ie, done, busy};
          REG_SRC:    cfg.read_data <= src;
          REG_DST:    cfg.read_data <= dst;
          REG_LEN:    cfg.read_data <= {16'd0, len};
          REG_REMAIN: cfg.read_data <= {16'd0, remain};
          default:    ;
        endcase
      end
    end
  end
endmodule

// File: rtl/rvx_dma.sv
// Single-channel word copy engine; 4 cycles/word against a 1-cycle responder.
// One initiator request outstanding at a time; each response wait cycle stalls the FSM.
module rvx_dma
  import rvx_dma_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  rvx_dma_if.slave  cfg,
  rvx_dma_if.master mem,
  output logic      irq
);
  state_t      state;
  logic [31:0] src_cnt;
  logic [31:0] dst_cnt;
  logic [15:0] remain;
  logic        done;
  logic        busy;
  logic        start;
  logic        done_clr;
  logic        ie;
  logic        ie_nxt;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        done_set;
  logic        done_nxt;

  rvx_dma_regs u_regs (
    .clock    (clock),
    .reset    (reset),
    .cfg      (cfg),
    .busy     (busy),
    .done     (done),
    .remain   (remain),
    .start    (start),
    .done_clr (done_clr),
    .ie       (ie),
    .ie_nxt   (ie_nxt),
    .src      (src),
    .dst      (dst),
    .len      (len)
  );

  assign busy     = (state != ST_IDLE);
  assign done_set = (start && (len == 16'd0)) ||
                    ((state == ST_WR_WAIT) && mem.write_response && (remain == 16'd1));
  // A set in the same cycle as a clear wins.
  assign done_nxt = done_set || (done && !(done_clr || start));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      src_cnt           <= '0;
      dst_cnt           <= '0;
      remain            <= '0;
      done              <= 1'b0;
      irq               <= 1'b0;
      mem.address       <= '0;
      mem.read_request  <= 1'b0;
      mem.write_data    <= '0;
      mem.write_strobe  <= 4'b0000;
      mem.write_request <= 1'b0;
    end else begin
      done <= done_nxt;
      irq  <= done_nxt && ie_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_cnt <= src;
            dst_cnt <= dst;
            remain  <= len;
            if (len != 16'd0) begin
              state            <= ST_RD_REQ;
              mem.read_request <= 1'b1;
              mem.address      <= src;
            end
          end
        end
        ST_RD_REQ: begin
          mem.read_request <= 1'b0;
          state            <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (mem.read_response) begin
            mem.write_data    <= mem.read_data;
            mem.write_request <= 1'b1;
            mem.write_strobe  <= 4'b1111;
            mem.address       <= dst_cnt;
            state             <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          mem.write_request <= 1'b0;
          mem.write_strobe  <= 4'b0000;
          state             <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (mem.write_response) begin
            src_cnt <= src_cnt + 32'd4;
            dst_cnt <= dst_cnt + 32'd4;
            remain  <= remain - 16'd1;
            if (remain == 16'd1) begin
              state <= ST_IDLE;
            end else begin
              state            <= ST_RD_REQ;
              mem.read_request <= 1'b1;
              mem.address      <= src_cnt + 32'd4;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
